// File: rtl/matrix_store_writer.sv
// Purpose: stores one matrix per request into a slot of the shared matrix BRAM (3-word header + row-major data) and tracks complete slots.
// Latency: all outputs registered; header words land 1..3 cycles after acceptance, each data element lands the cycle after it is accepted.
// Backpressure: write_ready gates requests (IDLE only); writer_ready gates elements (DATA only), dropping on the edge that takes the last element.
// Ports: clk/rst_n (async active-low); write_request/write_ready, write_matrix_id, write_rows, write_cols, write_name (request);
//        write_data/write_data_valid/writer_ready (element stream); write_done/write_error (pulses);
//        bram_wr_en/bram_wr_addr/bram_wr_data (BRAM write port); matrix_valid (per-slot complete flags).
module matrix_store_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14   // 8*BLOCK_SIZE must fit in 2^ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            write_matrix_id,
  input  logic [7:0]            write_rows,
  input  logic [7:0]            write_cols,
  input  logic [7:0][7:0]       write_name,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic [7:0]            matrix_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_BLOCK = ADDR_WIDTH'(BLOCK_SIZE);
  localparam logic [16:0]           LP_LIMIT = 17'(BLOCK_SIZE);

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_id, w_id_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [15:0]           r_total, w_total_nxt;
  logic [7:0][7:0]       r_name, w_name_nxt;
  logic [1:0]            r_hdr_cnt, w_hdr_cnt_nxt;
  logic [15:0]           r_count, w_count_nxt;
  logic                  r_write_ready, w_write_ready_nxt;
  logic                  r_writer_ready, w_writer_ready_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_error, w_error_nxt;
  logic                  r_en, w_en_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [7:0]            r_valid, w_valid_nxt;

  // Request decode, evaluated straight from the request inputs.
  logic [15:0]           w_total_req;
  logic                  w_reject;
  logic [ADDR_WIDTH-1:0] w_base_req;
  logic [DATA_WIDTH-1:0] w_hdr0, w_hdr1, w_hdr2;
  logic [15:0]           w_count_inc;

  assign w_total_req = {8'h00, write_rows} * {8'h00, write_cols};
  // 17-bit sum so 3+total cannot wrap before the size comparison.
  assign w_reject    = (write_rows == 8'd0) || (write_cols == 8'd0) ||
                       (({1'b0, w_total_req} + 17'd3) > LP_LIMIT);
  assign w_base_req  = ADDR_WIDTH'(write_matrix_id) * LP_BLOCK;
  assign w_hdr0      = DATA_WIDTH'({16'h0000, write_rows, write_cols});
  // Name character 0 goes to the most significant byte of the first name word.
  assign w_hdr1      = DATA_WIDTH'({r_name[0], r_name[1], r_name[2], r_name[3]});
  assign w_hdr2      = DATA_WIDTH'({r_name[4], r_name[5], r_name[6], r_name[7]});
  assign w_count_inc = r_count + 16'd1;

  always_comb begin
    w_state_nxt        = r_state;
    w_id_nxt           = r_id;
    w_base_nxt         = r_base;
    w_total_nxt        = r_total;
    w_name_nxt         = r_name;
    w_hdr_cnt_nxt      = r_hdr_cnt;
    w_count_nxt        = r_count;
    w_write_ready_nxt  = r_write_ready;
    w_writer_ready_nxt = r_writer_ready;
    w_addr_nxt         = r_addr;
    w_data_nxt         = r_data;
    w_valid_nxt        = r_valid;
    w_en_nxt           = 1'b0;
    w_done_nxt         = 1'b0;
    w_error_nxt        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (write_request && r_write_ready) begin
          if (w_reject) begin
            w_error_nxt = 1'b1;
          end else begin
            w_id_nxt                     = write_matrix_id;
            w_base_nxt                   = w_base_req;
            w_total_nxt                  = w_total_req;
            w_name_nxt                   = write_name;
            w_count_nxt                  = 16'd0;
            w_valid_nxt[write_matrix_id] = 1'b0;
            w_write_ready_nxt            = 1'b0;
            // Header word 0 is issued on the accepting edge; the name words follow.
            w_en_nxt                     = 1'b1;
            w_addr_nxt                   = w_base_req;
            w_data_nxt                   = w_hdr0;
            w_hdr_cnt_nxt                = 2'd1;
            w_state_nxt                  = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (r_hdr_cnt == 2'd3) begin
          w_writer_ready_nxt = 1'b1;
          w_state_nxt        = ST_DATA;
        end else begin
          w_en_nxt      = 1'b1;
          w_addr_nxt    = r_base + ADDR_WIDTH'(r_hdr_cnt);
          w_data_nxt    = (r_hdr_cnt == 2'd1) ? w_hdr1 : w_hdr2;
          w_hdr_cnt_nxt = r_hdr_cnt + 2'd1;
        end
      end
      ST_DATA: begin
        if (write_data_valid && r_writer_ready) begin
          w_en_nxt    = 1'b1;
          w_addr_nxt  = r_base + ADDR_WIDTH'(3) + ADDR_WIDTH'(r_count);
          w_data_nxt  = write_data;
          w_count_nxt = w_count_inc;
          if (w_count_inc == r_total) begin
            // Drop writer_ready on this same edge so no element beyond total is taken.
            w_writer_ready_nxt = 1'b0;
            w_done_nxt         = 1'b1;
            w_valid_nxt[r_id]  = 1'b1;
            w_state_nxt        = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_write_ready_nxt = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_id           <= 3'd0;
      r_base         <= '0;
      r_total        <= 16'd0;
      r_name         <= '0;
      r_hdr_cnt      <= 2'd0;
      r_count        <= 16'd0;
      r_write_ready  <= 1'b1;
      r_writer_ready <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_en           <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_valid        <= 8'h00;
    end else begin
      r_state        <= w_state_nxt;
      r_id           <= w_id_nxt;
      r_base         <= w_base_nxt;
      r_total        <= w_total_nxt;
      r_name         <= w_name_nxt;
      r_hdr_cnt      <= w_hdr_cnt_nxt;
      r_count        <= w_count_nxt;
      r_write_ready  <= w_write_ready_nxt;
      r_writer_ready <= w_writer_ready_nxt;
      r_done         <= w_done_nxt;
      r_error        <= w_error_nxt;
      r_en           <= w_en_nxt;
      r_addr         <= w_addr_nxt;
      r_data         <= w_data_nxt;
      r_valid        <= w_valid_nxt;
    end
  end

  assign write_ready  = r_write_ready;
  assign writer_ready = r_writer_ready;
  assign write_done   = r_done;
  assign write_error  = r_error;
  assign bram_wr_en   = r_en;
  assign bram_wr_addr = r_addr;
  assign bram_wr_data = r_data;
  assign matrix_valid = r_valid;

endmodule

// File: tb/tb_matrix_store_writer.sv
// Purpose: self-checking bench for matrix_store_writer against a transaction-level model of expected BRAM writes and flags.
// Latency: checks request/header/data/done timing relative to the accepting edge.
// Backpressure: drives gapped and junk element strobes to exercise writer_ready gating.
module tb_matrix_store_writer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            write_request = 1'b0;
  logic            write_ready;
  logic [2:0]      write_matrix_id = 3'd0;
  logic [7:0]      write_rows = 8'd0;
  logic [7:0]      write_cols = 8'd0;
  logic [7:0][7:0] write_name = '0;
  logic [31:0]     write_data = 32'd0;
  logic            write_data_valid = 1'b0;
  logic            writer_ready;
  logic            write_done;
  logic            write_error;
  logic            bram_wr_en;
  logic [13:0]     bram_wr_addr;
  logic [31:0]     bram_wr_data;
  logic [7:0]      matrix_valid;

  always #5 clk = ~clk;

  matrix_store_writer dut (
    .clk(clk), .rst_n(rst_n),
    .write_request(write_request), .write_ready(write_ready),
    .write_matrix_id(write_matrix_id), .write_rows(write_rows), .write_cols(write_cols),
    .write_name(write_name), .write_data(write_data), .write_data_valid(write_data_valid),
    .writer_ready(writer_ready), .write_done(write_done), .write_error(write_error),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .matrix_valid(matrix_valid)
  );

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] mem [0:16383];
  logic [7:0]  exp_valid = 8'h00;
  int          writes_seen = 0;
  int          dones_seen = 0;
  logic [13:0] last_addr = 14'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Every BRAM write must be the next one the model expects.
  always @(negedge clk) begin : cmp
    wr_t e;
    if (rst_n) begin
      if (bram_wr_en) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write: got addr 0x%0h data 0x%0h, expected no write", bram_wr_addr, bram_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("bram_addr", 64'(bram_wr_addr), 64'(e.a));
          chk("bram_data", 64'(bram_wr_data), 64'(e.d));
        end
        mem[bram_wr_addr] = bram_wr_data;
        last_addr = bram_wr_addr;
      end
      if (write_done) dones_seen++;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_write_ready"},  64'(write_ready),  64'(1));
    chk({tag, "_writer_ready"}, 64'(writer_ready), 64'(0));
    chk({tag, "_write_done"},   64'(write_done),   64'(0));
    chk({tag, "_write_error"},  64'(write_error),  64'(0));
    chk({tag, "_bram_wr_en"},   64'(bram_wr_en),   64'(0));
    chk({tag, "_bram_wr_addr"}, 64'(bram_wr_addr), 64'(0));
    chk({tag, "_bram_wr_data"}, 64'(bram_wr_data), 64'(0));
    chk({tag, "_matrix_valid"}, 64'(matrix_valid), 64'(0));
  endtask

  // name: first character in bits 63:56. seq: 0 random data, 1 data k+1, 2 0xDEADBEEF.
  // abort_after: nonzero pulses reset once that many elements have been written.
  task automatic do_write(input logic [2:0] id, input logic [7:0] rows, input logic [7:0] cols,
                          input logic [63:0] name, input int first_gap, input int max_gap,
                          input bit junk, input bit hold_req, input int abort_after, input int seq);
    int          total, idx, gaps, g, budget;
    bit          acc;
    logic [13:0] base;
    logic [31:0] d;
    wr_t         w;
    total = int'(rows) * int'(cols);
    acc   = (rows != 0) && (cols != 0) && (3 + total <= 1152);
    base  = 14'(int'(id) * 1152);
    budget = 0;
    while (!write_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("req_ready", 64'(write_ready), 64'(1));
    write_matrix_id = id;
    write_rows      = rows;
    write_cols      = cols;
    for (int i = 0; i < 8; i++) write_name[i] = name[63 - 8*i -: 8];
    write_request = 1'b1;
    if (acc) begin
      w.a = base;               w.d = {16'h0000, rows, cols}; exp_q.push_back(w);
      w.a = 14'(int'(base)+1);  w.d = name[63:32];            exp_q.push_back(w);
      w.a = 14'(int'(base)+2);  w.d = name[31:0];             exp_q.push_back(w);
    end
    @(negedge clk);
    idx = 1;
    if (!hold_req) write_request = 1'b0;
    write_matrix_id = 3'($urandom);
    write_rows      = 8'($urandom);
    write_cols      = 8'($urandom);
    write_name      = {$urandom, $urandom};
    if (!acc) begin
      chk("reject_error", 64'(write_error), 64'(1));
      chk("reject_ready", 64'(write_ready), 64'(1));
      @(negedge clk);
      chk("reject_error_clear", 64'(write_error), 64'(0));
      chk("reject_ready_hold", 64'(write_ready), 64'(1));
      return;
    end
    exp_valid[id] = 1'b0;
    chk("accept_ready_drop", 64'(write_ready), 64'(0));
    chk("accept_valid_clear", 64'(matrix_valid), 64'(exp_valid));
    chk("accept_no_error", 64'(write_error), 64'(0));
    while (!writer_ready && idx < 20) begin
      if (junk) begin
        write_data_valid = 1'($urandom);
        write_data       = $urandom;
      end
      @(negedge clk);
      idx++;
    end
    chk("writer_ready_latency", 64'(idx), 64'(4));
    write_data_valid = 1'b0;
    gaps = 0;
    for (int k = 0; k < total; k++) begin
      g = (k == 0) ? first_gap : int'($urandom_range(max_gap, 0));
      write_data_valid = 1'b0;
      for (int j = 0; j < g; j++) begin
        write_data = $urandom;
        @(negedge clk);
        idx++;
        gaps++;
      end
      d = (seq == 1) ? 32'(k + 1) : (seq == 2) ? 32'hDEADBEEF : $urandom;
      write_data       = d;
      write_data_valid = 1'b1;
      w.a = 14'(int'(base) + 3 + k);
      w.d = d;
      exp_q.push_back(w);
      @(negedge clk);
      idx++;
      if (abort_after == k + 1) begin
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_valid        = 8'h00;
        write_data_valid = 1'b0;
        write_request    = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    exp_valid[id] = 1'b1;
    if (hold_req) write_request = 1'b0;
    if (junk) write_data = $urandom;
    else write_data_valid = 1'b0;
    chk("done_pulse", 64'(write_done), 64'(1));
    chk("done_latency", 64'(idx), 64'(4 + total + gaps));
    chk("done_writer_ready", 64'(writer_ready), 64'(0));
    chk("done_write_ready", 64'(write_ready), 64'(0));
    chk("done_valid", 64'(matrix_valid), 64'(exp_valid));
    @(negedge clk);
    write_data_valid = 1'b0;
    chk("done_clear", 64'(write_done), 64'(0));
    chk("idle_write_ready", 64'(write_ready), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] nm;
    int w0, d0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("post_rst");

    // Slot 2, 2x3, continuous data 1..6.
    nm = "MATA    ";
    d0 = dones_seen;
    do_write(3'd2, 8'd2, 8'd3, nm, 0, 0, 1'b0, 1'b0, 0, 1);
    chk("t1_hdr0", 64'(mem[2304]), 64'h00000203);
    chk("t1_hdr1", 64'(mem[2305]), 64'h4D415441);
    chk("t1_hdr2", 64'(mem[2306]), 64'h20202020);
    chk("t1_first", 64'(mem[2307]), 64'd1);
    chk("t1_last", 64'(mem[2312]), 64'd6);
    chk("t1_done_once", 64'(dones_seen - d0), 64'd1);
    chk("t1_valid", 64'(matrix_valid), 64'h04);

    // Slot 7, 1x1, element delayed 5 cycles after writer_ready.
    w0 = writes_seen;
    do_write(3'd7, 8'd1, 8'd1, {$urandom, $urandom}, 5, 0, 1'b0, 1'b0, 0, 2);
    chk("t2_data", 64'(mem[8067]), 64'hDEADBEEF);
    chk("t2_writes", 64'(writes_seen - w0), 64'd4);
    chk("t2_valid", 64'(matrix_valid), 64'h84);

    // Rejects.
    w0 = writes_seen;
    d0 = dones_seen;
    do_write(3'd1, 8'd0,  8'd5,  {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0, 0);
    do_write(3'd1, 8'd5,  8'd0,  {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0, 0);
    do_write(3'd1, 8'd34, 8'd34, {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("rej_no_writes", 64'(writes_seen - w0), 64'd0);
    chk("rej_no_done", 64'(dones_seen - d0), 64'd0);
    chk("rej_valid", 64'(matrix_valid), 64'h84);

    // Largest expressible fit (28x41 = 1148) and the next product that overflows (25x46 = 1150).
    do_write(3'd0, 8'd28, 8'd41, {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("bound_last_addr", 64'(last_addr), 64'd1150);
    do_write(3'd0, 8'd25, 8'd46, {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("bound_valid", 64'(matrix_valid), 64'h85);

    // Rewrite slot 3, reset in the middle of the second write, then a clean write.
    do_write(3'd3, 8'd2, 8'd2, {$urandom, $urandom}, 0, 1, 1'b1, 1'b0, 0, 0);
    chk("rw_valid", 64'(matrix_valid), 64'h8D);
    do_write(3'd3, 8'd3, 8'd3, {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 4, 0);
    chk("rw_after_reset", 64'(matrix_valid), 64'h00);
    do_write(3'd5, 8'd2, 8'd3, {$urandom, $urandom}, 1, 2, 1'b1, 1'b0, 0, 0);
    chk("rw_new_valid", 64'(matrix_valid), 64'h20);

    // Request held high throughout a 2x2 write.
    w0 = writes_seen;
    d0 = dones_seen;
    do_write(3'd1, 8'd2, 8'd2, {$urandom, $urandom}, 0, 0, 1'b0, 1'b1, 0, 0);
    chk("hold_writes", 64'(writes_seen - w0), 64'd7);
    chk("hold_dones", 64'(dones_seen - d0), 64'd1);

    // Random traffic (zero dimensions give rejects).
    for (int r = 0; r < 10; r++) begin
      do_write(3'($urandom), 8'($urandom_range(6, 0)), 8'($urandom_range(6, 0)),
               {$urandom, $urandom}, int'($urandom_range(2, 0)), 2, 1'($urandom), 1'b0, 0, 0);
      chk("rand_valid", 64'(matrix_valid), 64'(exp_valid));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
